// File: rtl/lsu_subword_rmw.sv
// Load/store unit between the core memory stage and a word-only single-port RAM.
// Loads (LB/LH/LW/LBU/LHU) and SW map directly onto the RAM. SB/SH become a
// read-modify-write: read the word, merge the lane, write the word back.
// Optional build macro LSU_RANGE_CHECK_EN: when defined, any byte address
// outside the RAM (mem_addr[31:ADDR_WIDTH+2] != 0) is rejected like a
// misaligned access. When undefined, addresses alias modulo the RAM size.
module lsu_subword_rmw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic [2:0]            mem_funct3,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_busy,
    output logic                  mem_done,
    output logic                  mem_err,
    output logic [31:0]           dm_addr,
    output logic                  dm_w_en,
    output logic [DATA_WIDTH-1:0] dm_w_data,
    input  logic [DATA_WIDTH-1:0] dm_r_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_ADDR = 2'b01,
        RD_DATA = 2'b10,
        WR      = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [31:0]             addr_r;
    logic [2:0]              funct3_r;
    logic                    we_r;
    logic [DATA_WIDTH-1:0]   wbuf_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    done_r;
    logic                    err_r;
    logic                    illegal_s;
    logic                    range_err_s;
    logic [DATA_WIDTH-1:0]   load_s;
    logic [DATA_WIDTH-1:0]   merge_s;

    // Pick the addressed lane out of a RAM word and sign/zero extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte or half of a RAM word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000: begin
                case (off)
                    2'b00:   res[7:0]   = wd[7:0];
                    2'b01:   res[15:8]  = wd[7:0];
                    2'b10:   res[23:16] = wd[7:0];
                    2'b11:   res[31:24] = wd[7:0];
                    default: res[7:0]   = wd[7:0];
                endcase
            end
            3'b001: begin
                if (off[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

`ifdef LSU_RANGE_CHECK_EN
    assign range_err_s = (mem_addr[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
`else
    assign range_err_s = 1'b0;
`endif

    // Classify the incoming request: unknown funct3, store with unsigned
    // funct3, misaligned half/word, or (optionally) out-of-range address.
    always_comb begin
        illegal_s = 1'b0;
        case (mem_funct3)
            3'b000:  illegal_s = 1'b0;
            3'b001:  illegal_s = mem_addr[0];
            3'b010:  illegal_s = (mem_addr[1:0] != 2'b00);
            3'b100:  illegal_s = mem_we;
            3'b101:  illegal_s = mem_we | mem_addr[0];
            default: illegal_s = 1'b1;
        endcase
        illegal_s = illegal_s | range_err_s;
    end

    assign load_s  = extend_load(dm_r_data, funct3_r, addr_r[1:0]);
    assign merge_s = merge_store(dm_r_data, funct3_r, addr_r[1:0], wbuf_r);

    // Next-state logic: SW goes straight to WR, everything else reads first.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_req && !illegal_s) begin
                    state_s = (mem_we && (mem_funct3 == 3'b010)) ? WR : RD_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: state_s = RD_DATA;
            RD_DATA: state_s = we_r ? WR : IDLE;
            WR:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, write buffer, load result and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= 32'd0;
            funct3_r <= 3'd0;
            we_r     <= 1'b0;
            wbuf_r   <= {DATA_WIDTH{1'b0}};
            rdata_r  <= {DATA_WIDTH{1'b0}};
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_req) begin
                        addr_r   <= mem_addr;
                        funct3_r <= mem_funct3;
                        we_r     <= mem_we;
                        wbuf_r   <= mem_wdata;
                        done_r   <= illegal_s;
                        err_r    <= illegal_s;
                    end
                end
                RD_DATA: begin
                    if (we_r) begin
                        wbuf_r <= merge_s;
                    end else begin
                        rdata_r <= load_s;
                        done_r  <= 1'b1;
                    end
                end
                WR:      done_r <= 1'b1;
                default: done_r <= 1'b0;
            endcase
        end
    end

    // The RAM decodes only the low ADDR_WIDTH+2 bits; upper bits pass through.
    assign dm_addr   = {addr_r[31:ADDR_WIDTH+2], addr_r[ADDR_WIDTH+1:0]};
    assign dm_w_en   = (state_r == WR);
    assign dm_w_data = wbuf_r;
    assign mem_busy  = (state_r != IDLE);
    assign mem_done  = done_r;
    assign mem_err   = err_r;
    assign mem_rdata = rdata_r;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Bench for lsu_subword_rmw: a word RAM with registered address, a
// transaction-level reference (shadow memory plus per-op latency countdown)
// compared against the DUT every cycle, and literal spot checks.
module tb_lsu_subword_rmw;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req = 1'b0;
    logic [2:0]  mem_funct3 = 3'd0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;
    logic [31:0] dm_addr;
    logic        dm_w_en;
    logic [31:0] dm_w_data;
    logic [31:0] dm_r_data = 32'd0;

    logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'd0};
    logic [31:0] ref_mem [0:(1<<AW)-1] = '{default: 32'd0};

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // reference state
    int          m_cnt = 0;
    logic        m_we = 1'b0;
    logic [2:0]  m_f3 = 3'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wd = 32'd0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    lsu_subword_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_funct3(mem_funct3),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done),
        .mem_err(mem_err), .dm_addr(dm_addr), .dm_w_en(dm_w_en),
        .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd1024);
    endfunction

    function automatic bit tb_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        case (f3)
            3'd0:    sz = 1;
            3'd1:    sz = 2;
            3'd2:    sz = 4;
            3'd4:    sz = we ? 0 : 1;
            3'd5:    sz = we ? 0 : 2;
            default: sz = 0;
        endcase
        if (sz == 0) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
        if (a >= 32'd4096) return 1'b1;
`endif
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] tb_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        int sh;
        logic [31:0] v;
        sh = int'(a % 32'd4) * 8;
        case (f3)
            3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
            3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
            3'd4: v = (w >> sh) & 32'hFF;
            3'd5: v = (w >> sh) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        sh = int'(a % 32'd4) * 8;
        case (f3)
            3'd0:    mask = 32'hFF << sh;
            3'd1:    mask = 32'hFFFF << sh;
            default: mask = 32'hFFFFFFFF;
        endcase
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Word RAM with registered read address
    always @(posedge clk) begin
        if (dm_w_en) ram[dm_addr[AW+1:2]] <= dm_w_data;
        dm_r_data <= ram[dm_addr[AW+1:2]];
    end

    // Transaction-level reference: remaining-cycle countdown per accepted op
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            exp_done  <= 1'b0;
            exp_err   <= 1'b0;
            exp_rdata <= 32'd0;
        end else begin
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    exp_done <= 1'b1;
                    if (m_we) ref_mem[widx(m_addr)] <= tb_merge(ref_mem[widx(m_addr)], m_f3, m_addr, m_wd);
                    else      exp_rdata <= tb_load(ref_mem[widx(m_addr)], m_f3, m_addr);
                end
            end else if (mem_req) begin
                m_we   <= mem_we;
                m_f3   <= mem_funct3;
                m_addr <= mem_addr;
                m_wd   <= mem_wdata;
                if (tb_illegal(mem_we, mem_funct3, mem_addr)) begin
                    exp_done <= 1'b1;
                    exp_err  <= 1'b1;
                end else if (!mem_we) begin
                    m_cnt <= 2;
                end else if (mem_funct3 == 3'd2) begin
                    m_cnt <= 1;
                end else begin
                    m_cnt <= 3;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the reference
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",   32'(mem_busy), 32'(m_cnt != 0));
            chk("done",   32'(mem_done), 32'(exp_done));
            chk("err",    32'(mem_err),  32'(exp_err));
            chk("rdata",  mem_rdata,     exp_rdata);
            chk("w_en",   32'(dm_w_en),  32'(m_cnt == 1 && m_we));
            if (m_cnt == 1 && m_we) begin
                chk("w_data", dm_w_data, tb_merge(ref_mem[widx(m_addr)], m_f3, m_addr, m_wd));
                chk("w_addr", 32'(dm_addr[AW+1:2]), 32'(widx(m_addr)));
            end
        end
    end

    // Issue one request at a negedge while idle; return at the negedge showing mem_done
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
        @(negedge clk);
        mem_req = 1'b0;
        n = 0;
        while (mem_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (mem_done !== 1'b1) chk("done_timeout", 32'(mem_done), 32'd1);
    endtask

    initial begin
        int nbad;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_wen", 32'(dm_w_en), 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_w_data, 32'd0);
        check_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        op(1'b1, 3'd2, 32'h10, 32'h8899AABB);
        chk("sw_ram", ram[4], 32'h8899AABB);
        op(1'b0, 3'd0, 32'h11, 32'd0);
        chk("lb", mem_rdata, 32'hFFFFFFAA);
        chk("model_lb", exp_rdata, 32'hFFFFFFAA);
        op(1'b0, 3'd4, 32'h13, 32'd0);
        chk("lbu", mem_rdata, 32'h00000088);
        op(1'b0, 3'd1, 32'h12, 32'd0);
        chk("lh", mem_rdata, 32'hFFFF8899);
        chk("model_lh", exp_rdata, 32'hFFFF8899);
        op(1'b0, 3'd5, 32'h10, 32'd0);
        chk("lhu", mem_rdata, 32'h0000AABB);

        op(1'b1, 3'd0, 32'h12, 32'h12345677);
        chk("sb_ram", ram[4], 32'h8877AABB);
        chk("model_sb", ref_mem[4], 32'h8877AABB);
        op(1'b1, 3'd1, 32'h10, 32'h0000CAFE);
        chk("sh_ram", ram[4], 32'h8877CAFE);
        op(1'b0, 3'd2, 32'h10, 32'd0);
        chk("lw", mem_rdata, 32'h8877CAFE);

        op(1'b0, 3'd2, 32'h11, 32'd0);
        chk("lw_mis_err", 32'(mem_err), 32'd1);
        chk("lw_mis_rdata", mem_rdata, 32'h8877CAFE);
        op(1'b1, 3'd1, 32'h13, 32'hFFFF);
        chk("sh_mis_err", 32'(mem_err), 32'd1);
        op(1'b0, 3'd3, 32'h10, 32'd0);
        chk("f3_011_err", 32'(mem_err), 32'd1);
        op(1'b1, 3'd4, 32'h10, 32'd0);
        chk("sbu_err", 32'(mem_err), 32'd1);
        chk("err_ram", ram[4], 32'h8877CAFE);

        // back-to-back loads with other lanes
        op(1'b1, 3'd0, 32'h21, 32'h000000F0);
        op(1'b0, 3'd0, 32'h21, 32'd0);
        chk("lb_neg", mem_rdata, 32'hFFFFFFF0);
        op(1'b0, 3'd2, 32'h20, 32'd0);
        chk("lw_b2b", mem_rdata, 32'h0000F000);

        // reset while the SB is in RD_DATA
        mem_req = 1'b1; mem_we = 1'b1; mem_funct3 = 3'd0; mem_addr = 32'h10; mem_wdata = 32'hEE;
        @(negedge clk);
        mem_req = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ram", ram[4], 32'h8877CAFE);
        chk("rst_mid_rdata", mem_rdata, 32'd0);

        op(1'b1, 3'd2, 32'h1000, 32'h55AA55AA);
`ifdef LSU_RANGE_CHECK_EN
        chk("range_err", 32'(mem_err), 32'd1);
        chk("range_ram0", ram[0], 32'd0);
`else
        chk("alias_err", 32'(mem_err), 32'd0);
        chk("alias_ram0", ram[0], 32'h55AA55AA);
`endif
        @(negedge clk);
        check_en = 1'b0;

        nbad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            if (ram[i] !== ref_mem[i]) nbad++;
        end
        chk("ram_vs_model", 32'(nbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
